// File: rtl/cmd_saver_if.sv
// Byte-stream handshake carrying the /CMD file from cmd_saver to the upload path.
interface cmd_saver_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/cmd_saver.sv
// Serialises a RAM range into a TRS-80 /CMD stream (data blocks + exec block).
// Define CMD_SAVER_HEADER_EN to prefix the file with a type-05 name block.
//
// state      | meaning
// IDLE       | waiting for start
// HDR_TYPE   | header block type byte 05
// HDR_LEN    | header length byte 06
// HDR_NAME   | six name bytes, MSB first
// BLK_TYPE   | data block type 01, block size chosen here
// BLK_LEN    | data block length byte (n+2)
// BLK_LSB    | block load address LSB
// BLK_MSB    | block load address MSB
// RD_REQ     | RAM read strobe
// RD_WAIT    | RAM data captured
// DATA       | data byte presented
// EXE_TYPE   | exec block type 02
// EXE_LEN    | exec length byte 02
// EXE_LSB    | entry point LSB
// EXE_MSB    | entry point MSB, last byte of file
// DONE       | one-cycle completion pulse
module cmd_saver #(
    parameter int          ADDR = 16,
    parameter logic [47:0] NAME = 48'h4D4953544552
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [ADDR-1:0] start_addr,
    input  logic [ADDR-1:0] end_addr,
    input  logic [ADDR-1:0] exec_addr,
    output logic            mem_rd,
    output logic [ADDR-1:0] mem_addr,
    input  logic [7:0]      mem_data,
    cmd_saver_if.master     out_if,
    output logic            busy,
    output logic            done,
    output logic [23:0]     byte_count
);

    localparam logic [3:0] S_IDLE     = 4'd0;
`ifdef CMD_SAVER_HEADER_EN
    localparam logic [3:0] S_HDR_TYPE = 4'd1;
    localparam logic [3:0] S_HDR_LEN  = 4'd2;
    localparam logic [3:0] S_HDR_NAME = 4'd3;
`endif
    localparam logic [3:0] S_BLK_TYPE = 4'd4;
    localparam logic [3:0] S_BLK_LEN  = 4'd5;
    localparam logic [3:0] S_BLK_LSB  = 4'd6;
    localparam logic [3:0] S_BLK_MSB  = 4'd7;
    localparam logic [3:0] S_RD_REQ   = 4'd8;
    localparam logic [3:0] S_RD_WAIT  = 4'd9;
    localparam logic [3:0] S_DATA     = 4'd10;
    localparam logic [3:0] S_EXE_TYPE = 4'd11;
    localparam logic [3:0] S_EXE_LEN  = 4'd12;
    localparam logic [3:0] S_EXE_LSB  = 4'd13;
    localparam logic [3:0] S_EXE_MSB  = 4'd14;
    localparam logic [3:0] S_DONE     = 4'd15;

    logic [3:0]      state;
    logic [ADDR:0]   remaining;
    logic [8:0]      blk_left;
    logic [7:0]      blk_len;
    logic [ADDR-1:0] rd_addr;
    logic [ADDR-1:0] exec_reg;
    logic [7:0]      data_reg;
    logic [23:0]     cnt;

    logic [ADDR:0]   range_n;
    logic [8:0]      next_blk_n;
    logic [3:0]      first_state;
    logic            xfer;

`ifdef CMD_SAVER_HEADER_EN
    logic [47:0]     name_sr;
    logic [2:0]      name_cnt;
`else
    logic            unused_name;
    assign unused_name = ^NAME;
`endif

    assign range_n = (end_addr >= start_addr)
                   ? ({1'b0, end_addr} - {1'b0, start_addr} + 17'd1) : 17'd0;

    // A 255-byte tail would need length byte 01, which collides with nothing but
    // is avoided by splitting it into 254 + 1.
    assign next_blk_n = (remaining >= 17'd256) ? 9'd256 :
                        (remaining == 17'd255) ? 9'd254 : remaining[8:0];

`ifdef CMD_SAVER_HEADER_EN
    assign first_state = S_HDR_TYPE;
`else
    assign first_state = (range_n == 17'd0) ? S_EXE_TYPE : S_BLK_TYPE;
`endif

    assign xfer = out_if.out_valid & out_if.out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            blk_left  <= '0;
            blk_len   <= '0;
            rd_addr   <= '0;
            exec_reg  <= '0;
            data_reg  <= '0;
            cnt       <= '0;
`ifdef CMD_SAVER_HEADER_EN
            name_sr   <= '0;
            name_cnt  <= '0;
`endif
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            if (xfer)
                cnt <= cnt + 24'd1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= range_n;
                        rd_addr   <= start_addr;
                        exec_reg  <= exec_addr;
                        cnt       <= '0;
`ifdef CMD_SAVER_HEADER_EN
                        name_sr   <= NAME;
                        name_cnt  <= '0;
`endif
                        state     <= first_state;
                    end
                end
`ifdef CMD_SAVER_HEADER_EN
                S_HDR_TYPE: if (xfer) state <= S_HDR_LEN;
                S_HDR_LEN:  if (xfer) state <= S_HDR_NAME;
                S_HDR_NAME: begin
                    if (xfer) begin
                        name_sr  <= {name_sr[39:0], 8'h00};
                        name_cnt <= name_cnt + 3'd1;
                        if (name_cnt == 3'd5)
                            state <= (remaining == 17'd0) ? S_EXE_TYPE : S_BLK_TYPE;
                    end
                end
`endif
                S_BLK_TYPE: begin
                    if (xfer) begin
                        blk_left <= next_blk_n;
                        blk_len  <= next_blk_n[7:0] + 8'd2;
                        state    <= S_BLK_LEN;
                    end
                end
                S_BLK_LEN:  if (xfer) state <= S_BLK_LSB;
                S_BLK_LSB:  if (xfer) state <= S_BLK_MSB;
                S_BLK_MSB:  if (xfer) state <= S_RD_REQ;
                S_RD_REQ:   state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    data_reg <= mem_data;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    if (xfer) begin
                        rd_addr   <= rd_addr + 16'd1;
                        remaining <= remaining - 17'd1;
                        blk_left  <= blk_left - 9'd1;
                        if (blk_left != 9'd1)
                            state <= S_RD_REQ;
                        else if (remaining == 17'd1)
                            state <= S_EXE_TYPE;
                        else
                            state <= S_BLK_TYPE;
                    end
                end
                S_EXE_TYPE: if (xfer) state <= S_EXE_LEN;
                S_EXE_LEN:  if (xfer) state <= S_EXE_LSB;
                S_EXE_LSB:  if (xfer) state <= S_EXE_MSB;
                S_EXE_MSB:  if (xfer) state <= S_DONE;
                S_DONE:     state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // rd_addr sits at the block's first byte while the block header is sent.
    always_comb begin
        out_if.out_valid = 1'b0;
        out_if.out_data  = 8'h00;
        out_if.out_last  = 1'b0;
        case (state)
`ifdef CMD_SAVER_HEADER_EN
            S_HDR_TYPE: begin out_if.out_valid = 1'b1; out_if.out_data = 8'h05; end
            S_HDR_LEN:  begin out_if.out_valid = 1'b1; out_if.out_data = 8'h06; end
            S_HDR_NAME: begin out_if.out_valid = 1'b1; out_if.out_data = name_sr[47:40]; end
`endif
            S_BLK_TYPE: begin out_if.out_valid = 1'b1; out_if.out_data = 8'h01; end
            S_BLK_LEN:  begin out_if.out_valid = 1'b1; out_if.out_data = blk_len; end
            S_BLK_LSB:  begin out_if.out_valid = 1'b1; out_if.out_data = rd_addr[7:0]; end
            S_BLK_MSB:  begin out_if.out_valid = 1'b1; out_if.out_data = rd_addr[15:8]; end
            S_DATA:     begin out_if.out_valid = 1'b1; out_if.out_data = data_reg; end
            S_EXE_TYPE: begin out_if.out_valid = 1'b1; out_if.out_data = 8'h02; end
            S_EXE_LEN:  begin out_if.out_valid = 1'b1; out_if.out_data = 8'h02; end
            S_EXE_LSB:  begin out_if.out_valid = 1'b1; out_if.out_data = exec_reg[7:0]; end
            S_EXE_MSB: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = exec_reg[15:8];
                out_if.out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_rd     = (state == S_RD_REQ);
    assign mem_addr   = rd_addr;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign byte_count = cnt;

endmodule
